// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter: CPU MEM stage (port 0) vs. DMA (port 1).
// CPU wins by default; a starvation counter forces DMA slots and a lock holds the bus for bursts.
module dmem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_wait,
  input  logic        i_dma_req,
  input  logic        i_dma_wr,
  input  logic        i_dma_lock,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic        o_dma_gnt,
  output logic [31:0] o_dma_rdata,
  output logic        o_dma_err,
  input  logic        i_dma_err_clr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic {S_CPU, S_DMA} state_t;

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic [7:0]  r_burst_cnt;
  logic        r_dma_err;

  logic        w_cpu_acc;
  logic        w_dma_ok;
  logic        w_force;
  logic        w_cpu_gnt;
  logic        w_dma_gnt;
  logic        w_burst_last;

  // Grants are combinational so every beat completes in the cycle it is presented.
  always_comb begin
    w_cpu_acc    = i_cpu_rd | i_cpu_wr;
    w_dma_ok     = (i_dma_addr[31:10] == 22'd0);
    w_force      = i_dma_req && (r_starve_cnt == 4'(MAX_WAIT));
    w_burst_last = ({1'b0, r_burst_cnt} + 9'd1) == 9'(BURST_MAX);
    w_cpu_gnt    = 1'b0;
    w_dma_gnt    = 1'b0;
    if (!i_reset) begin
      if (r_state == S_DMA)  w_dma_gnt = i_dma_req;
      else if (w_force)      w_dma_gnt = 1'b1;
      else if (w_cpu_acc)    w_cpu_gnt = 1'b1;
      else                   w_dma_gnt = i_dma_req;
    end
  end

  // Out-of-range DMA beats are granted but never reach the bus strobes.
  always_comb begin
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    if (w_cpu_gnt) begin
      o_mem_rd    = i_cpu_rd;
      o_mem_wr    = i_cpu_wr;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_dma_gnt) begin
      o_mem_rd    = w_dma_ok & ~i_dma_wr;
      o_mem_wr    = w_dma_ok &  i_dma_wr;
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
    end
  end

  assign o_cpu_rdata = w_cpu_gnt ? i_mem_rdata : 32'd0;
  assign o_cpu_wait  = ~i_reset & w_cpu_acc & ~w_cpu_gnt;
  assign o_dma_gnt   = w_dma_gnt;
  assign o_dma_rdata = (w_dma_gnt & w_dma_ok) ? i_mem_rdata : 32'd0;
  assign o_dma_err   = r_dma_err & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_CPU;
      r_starve_cnt <= 4'd0;
      r_burst_cnt  <= 8'd0;
      r_dma_err    <= 1'b0;
    end else begin
      if (w_dma_gnt && !w_dma_ok) r_dma_err <= 1'b1;
      else if (i_dma_err_clr)     r_dma_err <= 1'b0;

      case (r_state)
        S_CPU: begin
          if (w_force) begin
            r_starve_cnt <= 4'd0;
          end else if (w_cpu_acc) begin
            if (!i_dma_req)                        r_starve_cnt <= 4'd0;
            else if (r_starve_cnt < 4'(MAX_WAIT))  r_starve_cnt <= r_starve_cnt + 4'd1;
          end else begin
            r_starve_cnt <= 4'd0;
          end
          if (w_dma_gnt && i_dma_lock && (BURST_MAX > 1)) begin
            r_state     <= S_DMA;
            r_burst_cnt <= 8'd1;
          end
        end
        S_DMA: begin
          if (!i_dma_req || !i_dma_lock || w_burst_last) begin
            r_state      <= S_CPU;
            r_burst_cnt  <= 8'd0;
            r_starve_cnt <= 4'd0;
          end else begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: begin
          r_state      <= S_CPU;
          r_burst_cnt  <= 8'd0;
          r_starve_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; memory returns the inverted bus address as read data.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, dma_req, dma_wr, dma_lock, dma_err_clr;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_wait, dma_gnt, dma_err, mem_rd, mem_wr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign mem_rdata = ~mem_addr;

  dmem_arbiter #(.MAX_WAIT(4), .BURST_MAX(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_wait(cpu_wait),
    .i_dma_req(dma_req), .i_dma_wr(dma_wr), .i_dma_lock(dma_lock), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .o_dma_gnt(dma_gnt), .o_dma_rdata(dma_rdata),
    .o_dma_err(dma_err), .i_dma_err_clr(dma_err_clr),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic wt, input logic g, input logic rd,
                     input logic wr, input logic [31:0] a);
    chk({tag, ".cpu_wait"}, 32'(cpu_wait), 32'(wt));
    chk({tag, ".dma_gnt"},  32'(dma_gnt),  32'(g));
    chk({tag, ".mem_rd"},   32'(mem_rd),   32'(rd));
    chk({tag, ".mem_wr"},   32'(mem_wr),   32'(wr));
    chk({tag, ".mem_addr"}, mem_addr,      a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; dma_req = 1'b1; dma_wr = 1'b0;
    dma_lock = 1'b0; dma_err_clr = 1'b0;
    cpu_addr = 32'h10; cpu_wdata = 32'h0; dma_addr = 32'h20; dma_wdata = 32'h0;

    // Reset: everything quiet even with requests pending
    settle(); bus("rst", 0, 0, 0, 0, 32'h0);
    chk("rst.cpu_rdata", cpu_rdata, 32'h0);
    chk("rst.dma_rdata", dma_rdata, 32'h0);
    chk("rst.dma_err", 32'(dma_err), 32'h0);
    tick();
    reset = 1'b0; cpu_rd = 1'b0; dma_req = 1'b0; cpu_addr = 32'h0; dma_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle(); bus($sformatf("idle%0d", i), 0, 0, 0, 0, 32'h0); tick();
    end

    // CPU write
    cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    settle(); bus("cpuwr", 0, 0, 0, 1, 32'h10);
    chk("cpuwr.wdata", mem_wdata, 32'hDEADBEEF);
    tick(); cpu_wr = 1'b0;

    // Starvation: 4 CPU wins, forced DMA slot, CPU again
    cpu_rd = 1'b1; cpu_addr = 32'h80; dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (i == 4) begin
        bus($sformatf("starve%0d", i), 1, 1, 1, 0, 32'h20);
        chk("starve.dma_rdata", dma_rdata, ~32'h20);
        chk("starve.cpu_rdata", cpu_rdata, 32'h0);
      end else begin
        bus($sformatf("starve%0d", i), 0, 0, 1, 0, 32'h80);
        chk($sformatf("starve%0d.cpu_rdata", i), cpu_rdata, ~32'h80);
      end
      tick();
    end
    cpu_rd = 1'b0; dma_req = 1'b0;
    settle(); tick();

    // Locked write burst capped at 8 beats; CPU waits on beat 8, wins the gap
    dma_req = 1'b1; dma_wr = 1'b1; dma_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dma_addr = 32'h100 + 32'(4 * i); dma_wdata = 32'(i);
      if (i == 7) begin cpu_rd = 1'b1; cpu_addr = 32'h44; end
      settle();
      bus($sformatf("burst%0d", i), logic'(i == 7), 1, 0, 1, 32'h100 + 32'(4 * i));
      chk($sformatf("burst%0d.wdata", i), mem_wdata, 32'(i));
      tick();
    end
    dma_addr = 32'h120; dma_wdata = 32'h8;
    settle(); bus("gap", 0, 0, 1, 0, 32'h44);
    chk("gap.cpu_rdata", cpu_rdata, ~32'h44);
    tick(); cpu_rd = 1'b0;
    settle(); bus("beat9", 0, 1, 0, 1, 32'h120); tick();
    dma_addr = 32'h124;
    settle(); bus("beat10", 0, 1, 0, 1, 32'h124); tick();
    dma_req = 1'b0; dma_lock = 1'b0;
    settle(); bus("burstend", 0, 0, 0, 0, 32'h0); tick();

    // Forced locked burst, lock dropped on beat 3
    cpu_rd = 1'b1; cpu_addr = 32'h48; dma_req = 1'b1; dma_wr = 1'b0; dma_lock = 1'b1;
    dma_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      settle(); bus($sformatf("lk_cpu%0d", i), 0, 0, 1, 0, 32'h48); tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dma_lock = 1'b0;
      settle(); bus($sformatf("lk_beat%0d", i), 1, 1, 1, 0, 32'h30); tick();
    end
    dma_req = 1'b0;
    settle(); bus("lk_back", 0, 0, 1, 0, 32'h48); tick();
    cpu_rd = 1'b0;

    // Out-of-range DMA write: granted, suppressed, sticky error
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h40000010; dma_wdata = 32'h1234;
    settle(); bus("oor", 0, 1, 0, 0, 32'h40000010);
    chk("oor.err_now", 32'(dma_err), 32'h0);
    tick(); dma_req = 1'b0;
    settle(); chk("oor.err_set", 32'(dma_err), 32'h1); tick();
    settle(); chk("oor.err_hold", 32'(dma_err), 32'h1); tick();
    dma_err_clr = 1'b1;
    settle(); chk("oor.err_clrcyc", 32'(dma_err), 32'h1); tick();
    dma_err_clr = 1'b0;
    settle(); chk("oor.err_clr", 32'(dma_err), 32'h0); tick();
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h3FC;
    settle(); bus("edge_in", 0, 1, 1, 0, 32'h3FC);
    chk("edge_in.rdata", dma_rdata, ~32'h3FC);
    tick(); dma_req = 1'b0;
    settle(); chk("edge_in.err", 32'(dma_err), 32'h0); tick();
    dma_req = 1'b1; dma_addr = 32'h400; dma_err_clr = 1'b1;
    settle(); bus("edge_out", 0, 1, 0, 0, 32'h400);
    chk("edge_out.rdata", dma_rdata, 32'h0);
    tick(); dma_req = 1'b0; dma_err_clr = 1'b0;
    settle(); chk("setwins.err", 32'(dma_err), 32'h1); tick();

    // Reset on beat 4 of a locked burst
    dma_req = 1'b1; dma_wr = 1'b1; dma_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dma_addr = 32'h200 + 32'(4 * i);
      settle(); bus($sformatf("rb%0d", i), 0, 1, 0, 1, 32'h200 + 32'(4 * i)); tick();
    end
    reset = 1'b1; dma_addr = 32'h20C;
    settle(); bus("rb_rst", 0, 0, 0, 0, 32'h0);
    chk("rb_rst.err", 32'(dma_err), 32'h0);
    tick();
    reset = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h4C;
    for (int i = 0; i < 4; i++) begin
      settle(); bus($sformatf("rb_cpu%0d", i), 0, 0, 1, 0, 32'h4C); tick();
    end
    dma_lock = 1'b0;
    settle(); bus("rb_force", 1, 1, 0, 1, 32'h20C);
    chk("rb_force.err", 32'(dma_err), 32'h0);
    tick();
    cpu_rd = 1'b0; dma_req = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/peripheral bus between the CPU MEM stage (port 0) and a DMA requester (port 1).
- The CPU normally wins arbitration. A starvation counter forces a DMA slot after MAX_WAIT consecutive losses.
- A DMA lock holds the bus for a burst of up to BURST_MAX beats.
- Sits between the pipeline MEM stage and the data memory block; it drives that block's rd/wr/addr/wdata and returns its rdata.

Parameters:
- MAX_WAIT, 4, consecutive cycles a pending DMA request may lose before it is granted by force (1..15).
- BURST_MAX, 8, maximum beats granted to one locked DMA burst (1..255).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_rd  in  1  CPU read request this cycle.
- cpu_wr  in  1  CPU write request this cycle.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data to CPU; 0 when the CPU is not granted.
- cpu_wait  out  1  CPU access not serviced this cycle; the CPU holds its request and repeats it.
- dma_req  in  1  DMA access request.
- dma_wr  in  1  1 = write, 0 = read; valid when dma_req = 1.
- dma_lock  in  1  request to keep ownership for further beats.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA beat serviced this cycle.
- dma_rdata  out  32  read data to DMA; 0 when not granted.
- dma_err  out  1  sticky flag: a DMA beat targeted an address outside RAM.
- dma_err_clr  in  1  clears dma_err.
- mem_rd  out  1  bus read strobe.
- mem_wr  out  1  bus write strobe.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_rdata  in  32  bus read data (combinational from memory).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). While reset = 1, all outputs are 0 (grants, strobes, cpu_wait, dma_err).
- State reset values: state = S_CPU, starve_cnt = 0, burst_cnt = 0, dma_err = 0.
- Timing: grant decisions are combinational from the inputs and registered state, so each beat has zero-cycle latency. A read returns mem_rdata in the same cycle; a write commits at the next posedge.
- Signal definitions:
  - cpu_acc = cpu_rd | cpu_wr.
  - If cpu_rd and cpu_wr are both 1, the beat is treated as a write with mem_rd = 1 as well, passed through unchanged.
- Bus muxing: the granted port drives mem_addr, mem_wdata and the strobes. With no grant, all mem_* outputs are 0.
- State S_CPU:
  - force = dma_req & (starve_cnt == MAX_WAIT).
  - force = 1: DMA is granted; cpu_wait = cpu_acc; starve_cnt <= 0.
  - Else if cpu_acc = 1: CPU is granted; cpu_wait = 0. starve_cnt <= starve_cnt + 1 if dma_req, otherwise 0.
  - Else if dma_req = 1: DMA is granted; starve_cnt <= 0.
  - Idle: starve_cnt <= 0.
  - A granted DMA beat with dma_lock = 1 and BURST_MAX > 1 moves to S_DMA with burst_cnt <= 1.
- State S_DMA:
  - The CPU is never granted; cpu_wait = cpu_acc.
  - While dma_req = 1, each cycle is a granted beat and burst_cnt increments.
  - Return to S_CPU (burst_cnt <= 0, starve_cnt <= 0) at the posedge after a cycle in which any of these holds:
    - dma_req = 0 (no beat that cycle);
    - dma_lock = 0 (that beat is still granted);
    - burst_cnt + 1 == BURST_MAX (that beat is the last).
  - The CPU is serviceable in the first cycle back in S_CPU.
- Address check: DMA may only reach RAM, i.e. dma_addr[31:10] == 0.
  - An out-of-range DMA beat still asserts dma_gnt and counts toward the burst.
  - mem_rd/mem_wr are suppressed for that beat and dma_rdata = 0.
  - dma_err <= 1 at the next posedge.
- dma_err handling: sticky until dma_err_clr or reset. If clr and a new error occur in the same cycle, the set wins.
- Counter widths: starve_cnt is 4 bits and saturates at MAX_WAIT; burst_cnt is 8 bits and never exceeds BURST_MAX.
- Reset mid-burst: the next state is S_CPU, counters are 0, and no beat is granted during the reset cycle.

Test Plan:
- Reset, then idle for 3 cycles -> all outputs 0; after a CPU write to addr 0x10, data 0xDEADBEEF: mem_wr = 1, mem_addr = 0x10, cpu_wait = 0.
- CPU reads every cycle and DMA read requests 0x20 continuously (MAX_WAIT = 4) -> cycles 0-3 CPU granted; cycle 4 dma_gnt = 1 and cpu_wait = 1; cycle 5 CPU granted again.
- CPU idle, DMA locked write burst of 10 beats starting at 0x100 (BURST_MAX = 8) -> 8 consecutive dma_gnt, then one S_CPU cycle in which a waiting CPU access is granted; the DMA resumes after that.
- DMA lock with dma_lock dropped on beat 3 and CPU requesting throughout -> cpu_wait = 1 for beats 1-3; CPU granted in cycle 4.
- DMA write to 0x40000010 -> dma_gnt = 1, mem_wr = 0, dma_err = 1 next cycle; it stays set until dma_err_clr; a simultaneous clr and new error leaves it at 1.
- Reset asserted during beat 4 of a locked burst -> dma_gnt = 0 that cycle; after release the CPU is granted immediately and starve_cnt restarts from 0.
